// File: rtl/card_shoe_dealer_if.sv
// rtl/card_shoe_dealer_if.sv - draw/shuffle request and dealt-card bus of the card shoe dealer
//
// Signals:
//   draw, shuffle_req         requests from the game FSM to the shoe
//   card_out, card_rank       last dealt card (value 1..10, rank 1..13)
//   card_valid                one-cycle pulse per dealt card
//   ready, shuffling          shoe status
//   cards_left, low_deck      undealt card count and low-shoe warning
// Modports: master = game FSM side, slave = dealer side.
interface card_shoe_dealer_if;
    logic       draw;
    logic       shuffle_req;
    logic [3:0] card_out;
    logic [3:0] card_rank;
    logic       card_valid;
    logic       ready;
    logic       shuffling;
    logic [5:0] cards_left;
    logic       low_deck;

    modport master (
        output draw, shuffle_req,
        input  card_out, card_rank, card_valid, ready, shuffling, cards_left, low_deck
    );

    modport slave (
        input  draw, shuffle_req,
        output card_out, card_rank, card_valid, ready, shuffling, cards_left, low_deck
    );
endinterface

// File: rtl/card_shoe_dealer.sv
// rtl/card_shoe_dealer.sv - 52-card shoe with LFSR-driven Fisher-Yates shuffle and one-card-per-draw dealing
//
// Ports:
//   clk    in   system clock, all logic on posedge
//   reset  in   asynchronous active-high reset
//   bus    slave modport of card_shoe_dealer_if (draw/shuffle_req in, dealt card and status out)
// Parameters:
//   LFSR_SEED     reset value of the 16-bit Galois LFSR (0 is replaced by 1)
//   RESHUFFLE_AT  low_deck asserts when cards_left is below this value
//   AUTO_SHUFFLE  1: reshuffle by itself once the shoe is empty; 0: wait for shuffle_req
module card_shoe_dealer #(
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter int          RESHUFFLE_AT = 15,
    parameter bit          AUTO_SHUFFLE = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    card_shoe_dealer_if.slave    bus
);

    localparam logic [1:0] ST_FILL    = 2'd0;
    localparam logic [1:0] ST_SHUFFLE = 2'd1;
    localparam logic [1:0] ST_READY   = 2'd2;

    localparam logic [15:0] SEED   = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0] TAPS   = 16'hB400;
    localparam logic [5:0]  LOW_AT = 6'(RESHUFFLE_AT);

    logic [1:0]  state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [5:0]  idx_q, idx_d;          // fill position k in FILL, swap position i in SHUFFLE
    logic [3:0]  fill_rank_q, fill_rank_d;
    logic [5:0]  ptr_q, ptr_d;
    logic [5:0]  left_q, left_d;
    logic [3:0]  card_out_q, card_out_d;
    logic [3:0]  card_rank_q, card_rank_d;
    logic        card_valid_q, card_valid_d;

    logic [3:0]  deck [0:51];
    logic [5:0]  swap_j;
    logic        swap_ok;
    logic [3:0]  deal_rank;

    assign swap_j    = lfsr_q[5:0];
    // Rejection sampling: an out-of-range j simply burns one cycle and the LFSR moves on.
    assign swap_ok   = (state_q == ST_SHUFFLE) && (swap_j <= idx_q);
    assign deal_rank = deck[ptr_q];

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        fill_rank_d  = fill_rank_q;
        ptr_d        = ptr_q;
        left_d       = left_q;
        card_out_d   = card_out_q;
        card_rank_d  = card_rank_q;
        card_valid_d = 1'b0;
        lfsr_d       = lfsr_q[0] ? ({1'b0, lfsr_q[15:1]} ^ TAPS) : {1'b0, lfsr_q[15:1]};

        case (state_q)
            ST_FILL: begin
                idx_d       = idx_q + 6'd1;
                fill_rank_d = (fill_rank_q == 4'd13) ? 4'd1 : fill_rank_q + 4'd1;
                if (idx_q == 6'd51) begin
                    state_d = ST_SHUFFLE;
                    idx_d   = 6'd51;
                end
            end
            ST_SHUFFLE: begin
                if (swap_ok) begin
                    if (idx_q == 6'd1) begin
                        state_d = ST_READY;
                        ptr_d   = 6'd0;
                        left_d  = 6'd52;
                    end else begin
                        idx_d = idx_q - 6'd1;
                    end
                end
            end
            ST_READY: begin
                if (bus.shuffle_req) begin
                    state_d = ST_SHUFFLE;
                    idx_d   = 6'd51;
                    ptr_d   = 6'd0;
                    left_d  = 6'd0;
                end else if (bus.draw && left_q != 6'd0) begin
                    card_rank_d  = deal_rank;
                    card_out_d   = (deal_rank > 4'd10) ? 4'd10 : deal_rank;
                    card_valid_d = 1'b1;
                    ptr_d        = ptr_q + 6'd1;
                    left_d       = left_q - 6'd1;
                end else if (AUTO_SHUFFLE && left_q == 6'd0) begin
                    state_d = ST_SHUFFLE;
                    idx_d   = 6'd51;
                    ptr_d   = 6'd0;
                end
            end
            default: begin
                state_d     = ST_FILL;
                idx_d       = 6'd0;
                fill_rank_d = 4'd1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_FILL;
            lfsr_q       <= SEED;
            idx_q        <= 6'd0;
            fill_rank_q  <= 4'd1;
            ptr_q        <= 6'd0;
            left_q       <= 6'd0;
            card_out_q   <= 4'd0;
            card_rank_q  <= 4'd0;
            card_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            idx_q        <= idx_d;
            fill_rank_q  <= fill_rank_d;
            ptr_q        <= ptr_d;
            left_q       <= left_d;
            card_out_q   <= card_out_d;
            card_rank_q  <= card_rank_d;
            card_valid_q <= card_valid_d;
        end
    end

    // Deck storage needs no reset: FILL rewrites every entry before any card is dealt.
    // When j == i both writes carry the same value, so the write order does not matter.
    always_ff @(posedge clk) begin
        if (state_q == ST_FILL) begin
            deck[idx_q] <= fill_rank_q;
        end else if (swap_ok) begin
            deck[idx_q]  <= deck[swap_j];
            deck[swap_j] <= deck[idx_q];
        end
    end

    assign bus.card_out   = card_out_q;
    assign bus.card_rank  = card_rank_q;
    assign bus.card_valid = card_valid_q;
    assign bus.cards_left = left_q;
    assign bus.ready      = (state_q == ST_READY) && (left_q != 6'd0);
    assign bus.low_deck   = (state_q == ST_READY) && (left_q < LOW_AT);
    // The reset state is FILL, so shuffling is masked while reset is held to keep all outputs at 0.
    assign bus.shuffling  = ~reset && ((state_q == ST_FILL) || (state_q == ST_SHUFFLE));

endmodule

// File: tb/tb_card_shoe_dealer.sv
// tb/tb_card_shoe_dealer.sv - directed self-checking bench for card_shoe_dealer
module tb_card_shoe_dealer;

    logic clk;
    logic reset;

    card_shoe_dealer_if bus ();
    card_shoe_dealer_if bus2 ();

    assign bus2.draw        = bus.draw;
    assign bus2.shuffle_req = bus.shuffle_req;

    card_shoe_dealer #(.LFSR_SEED(16'hACE1), .RESHUFFLE_AT(15), .AUTO_SHUFFLE(1'b0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    card_shoe_dealer #(.LFSR_SEED(16'hACE1), .RESHUFFLE_AT(15), .AUTO_SHUFFLE(1'b1)) dut_auto (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!bus.ready && n < 5000) begin
            step();
            n++;
        end
    endtask

    logic [15:0] l;
    logic [3:0]  md [52];
    logic [3:0]  tmp;
    int          mcnt;
    int          n;
    int          rc [14];

    function automatic logic [15:0] adv(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    function automatic logic [3:0] val(input logic [3:0] r);
        return (r > 4'd10) ? 4'd10 : r;
    endfunction

    initial begin
        // Reference shuffle from the seed: 52 FILL cycles, then rejection-sampled swaps.
        for (int k = 0; k < 52; k++) md[k] = 4'((k % 13) + 1);
        l = 16'hACE1;
        repeat (52) l = adv(l);
        mcnt = 0;
        for (int i = 51; i >= 1; ) begin
            logic [5:0] j;
            mcnt++;
            j = l[5:0];
            if (int'(j) <= i) begin
                tmp = md[i]; md[i] = md[j]; md[j] = tmp;
                i--;
            end
            l = adv(l);
        end
        for (int r = 0; r < 14; r++) rc[r] = 0;

        // T1: reset and first shuffle
        reset = 1'b1;
        bus.draw = 1'b0;
        bus.shuffle_req = 1'b0;
        step(); step();
        chk("rst_shuffling", bus.shuffling, 0);
        chk("rst_ready", bus.ready, 0);
        chk("rst_card_out", bus.card_out, 0);
        chk("rst_cards_left", bus.cards_left, 0);
        reset = 1'b0;
        step();
        chk("t1_shuffling_cycle1", bus.shuffling, 1);
        wait_ready(n);
        chk("t1_ready_latency", n + 1, 52 + mcnt);
        chk("t1_cards_left", bus.cards_left, 52);
        chk("t1_low_deck", bus.low_deck, 0);
        chk("t1_shuffling_done", bus.shuffling, 0);

        // T2: 52 single draws against the reference deck order
        for (int d = 0; d < 52; d++) begin
            bus.draw = 1'b1;
            step();
            bus.draw = 1'b0;
            chk("t2_valid", bus.card_valid, 1);
            chk("t2_rank", bus.card_rank, md[d]);
            chk("t2_value", bus.card_out, val(bus.card_rank));
            chk("t2_cards_left", bus.cards_left, 51 - d);
            chk("t2_low_deck", bus.low_deck, ((51 - d) < 15) ? 1 : 0);
            chk("t2_ready", bus.ready, ((51 - d) != 0) ? 1 : 0);
            rc[bus.card_rank]++;
            step();
            chk("t2_valid_pulse", bus.card_valid, 0);
        end
        for (int r = 1; r < 14; r++) chk("t2_rank_count", rc[r], 4);
        chk("t2_auto_shuffling", bus2.shuffling, 1);
        chk("t2_auto_cards_left", bus2.cards_left, 0);

        // T3: draw on empty shoe, then manual reshuffle
        bus.draw = 1'b1;
        step();
        bus.draw = 1'b0;
        chk("t3_empty_valid", bus.card_valid, 0);
        chk("t3_card_out_hold", bus.card_out, val(md[51]));
        chk("t3_shuffling_idle", bus.shuffling, 0);
        bus.shuffle_req = 1'b1;
        step();
        bus.shuffle_req = 1'b0;
        chk("t3_shuffling", bus.shuffling, 1);
        wait_ready(n);
        chk("t3_reshuffle_done", (n < 5000) ? 1 : 0, 1);
        chk("t3_cards_left", bus.cards_left, 52);

        // T4: draw held high for 5 cycles
        bus.draw = 1'b1;
        for (int d = 0; d < 5; d++) begin
            step();
            chk("t4_valid", bus.card_valid, 1);
            chk("t4_cards_left", bus.cards_left, 51 - d);
        end
        bus.draw = 1'b0;
        step();
        chk("t4_valid_end", bus.card_valid, 0);
        chk("t4_cards_left_end", bus.cards_left, 47);

        // T5: shuffle_req wins over draw
        bus.draw = 1'b1;
        bus.shuffle_req = 1'b1;
        step();
        bus.draw = 1'b0;
        bus.shuffle_req = 1'b0;
        chk("t5_no_card", bus.card_valid, 0);
        chk("t5_shuffling", bus.shuffling, 1);
        chk("t5_cards_left", bus.cards_left, 0);
        wait_ready(n);
        chk("t5_cards_left_done", bus.cards_left, 52);

        // T6a: reset in the middle of a shuffle
        bus.shuffle_req = 1'b1;
        step();
        bus.shuffle_req = 1'b0;
        repeat (10) step();
        #3 reset = 1'b1;
        #1;
        chk("t6_mid_shuffle_shuffling", bus.shuffling, 0);
        chk("t6_mid_shuffle_card_out", bus.card_out, 0);
        step();
        reset = 1'b0;
        step();
        wait_ready(n);
        chk("t6_rerun_latency", n + 1, 52 + mcnt);

        // T6b: reset in the middle of dealing, then deterministic rerun
        bus.draw = 1'b1;
        step();
        chk("t6_deal0", bus.card_rank, md[0]);
        step();
        chk("t6_deal1", bus.card_rank, md[1]);
        #3 reset = 1'b1;
        #1;
        chk("t6_mid_deal_valid", bus.card_valid, 0);
        chk("t6_mid_deal_card_out", bus.card_out, 0);
        chk("t6_mid_deal_card_rank", bus.card_rank, 0);
        chk("t6_mid_deal_cards_left", bus.cards_left, 0);
        chk("t6_mid_deal_ready", bus.ready, 0);
        bus.draw = 1'b0;
        step();
        reset = 1'b0;
        step();
        wait_ready(n);
        chk("t6_rerun2_latency", n + 1, 52 + mcnt);
        bus.draw = 1'b1;
        for (int d = 0; d < 3; d++) begin
            step();
            chk("t6_rerun_rank", bus.card_rank, md[d]);
        end
        bus.draw = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
